// File: rtl/template_matcher_if.sv
// Bundles the matcher's control handshake and its two synchronous read ports.
// The slave modport is the matcher. The master modport is the buffer/transmit side that drives it.
interface template_matcher_if #(
    parameter int unsigned SAMPLE_W = 10,
    parameter int unsigned ACC_W    = 22
) ();
    logic                start;
    logic                ack;
    logic [10:0]         audio_addr;
    logic [SAMPLE_W-1:0] audio_data;
    logic [12:0]         tmpl_addr;
    logic [SAMPLE_W-1:0] tmpl_data;
    logic                busy;
    logic                done;
    logic [3:0]          result;
    logic [ACC_W-1:0]    score;

    modport master (
        output start, ack, audio_data, tmpl_data,
        input  audio_addr, tmpl_addr, busy, done, result, score
    );

    modport slave (
        input  start, ack, audio_data, tmpl_data,
        output audio_addr, tmpl_addr, busy, done, result, score
    );
endinterface

// File: rtl/template_matcher.sv
// SAD template matcher: scores the input buffer against each stored template.
// Reports the best index, or 4'hF when even the best score exceeds THRESH.
module template_matcher #(
    parameter int unsigned       N_SAMPLES = 2000,
    parameter int unsigned       N_WORDS   = 4,
    parameter int unsigned       SAMPLE_W  = 10,
    parameter int unsigned       ACC_W     = 22,
    parameter logic [ACC_W-1:0]  THRESH    = 400000
) (
    input logic              clk,
    input logic              reset,
    template_matcher_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StCmp, StDone} state_t;

    state_t              state_q, state_d;
    logic [10:0]         j_q, j_d;
    logic [3:0]          w_q, w_d;
    logic [12:0]         base_q, base_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    best_score_q, best_score_d;
    logic [3:0]          best_idx_q, best_idx_d;
    logic                valid_q, valid_d;
    logic [10:0]         audio_addr_q, audio_addr_d;
    logic [12:0]         tmpl_addr_q, tmpl_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [3:0]          result_q, result_d;
    logic [ACC_W-1:0]    score_q, score_d;

    logic [SAMPLE_W-1:0] abs_diff;
    logic [ACC_W-1:0]    cmp_score;
    logic [3:0]          cmp_idx;

    always_comb begin
        abs_diff = (bus.audio_data >= bus.tmpl_data) ? bus.audio_data - bus.tmpl_data
                                                     : bus.tmpl_data - bus.audio_data;
        // Strict less-than keeps the lower index on ties.
        cmp_score = best_score_q;
        cmp_idx   = best_idx_q;
        if (acc_q < best_score_q) begin
            cmp_score = acc_q;
            cmp_idx   = w_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        j_d          = j_q;
        w_d          = w_q;
        base_d       = base_q;
        acc_d        = acc_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        audio_addr_d = audio_addr_q;
        tmpl_addr_d  = tmpl_addr_q;
        busy_d       = busy_q;
        done_d       = done_q;
        result_d     = result_q;
        score_d      = score_q;
        // Read data returns one cycle after each RUN address, so the sample issued in the last RUN
        // cycle lands in DRAIN.
        valid_d      = (state_q == StRun);
        if (valid_q) begin
            acc_d = acc_q + ACC_W'(abs_diff);
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d      = StRun;
                    j_d          = '0;
                    w_d          = '0;
                    base_d       = '0;
                    acc_d        = '0;
                    best_score_d = '1;
                    best_idx_d   = '0;
                    audio_addr_d = '0;
                    tmpl_addr_d  = '0;
                    busy_d       = 1'b1;
                end
            end
            StRun: begin
                if (j_q == 11'(N_SAMPLES - 1)) begin
                    state_d = StDrain;
                end else begin
                    j_d          = j_q + 11'd1;
                    audio_addr_d = j_q + 11'd1;
                    tmpl_addr_d  = tmpl_addr_q + 13'd1;
                end
            end
            StDrain: begin
                state_d = StCmp;
            end
            StCmp: begin
                best_score_d = cmp_score;
                best_idx_d   = cmp_idx;
                acc_d        = '0;
                j_d          = '0;
                if (w_q < 4'(N_WORDS - 1)) begin
                    w_d          = w_q + 4'd1;
                    base_d       = base_q + 13'(N_SAMPLES);
                    audio_addr_d = '0;
                    tmpl_addr_d  = base_q + 13'(N_SAMPLES);
                    state_d      = StRun;
                end else begin
                    state_d  = StDone;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    score_d  = cmp_score;
                    result_d = (cmp_score > THRESH) ? 4'hF : cmp_idx;
                end
            end
            StDone: begin
                if (bus.ack) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            j_q          <= '0;
            w_q          <= '0;
            base_q       <= '0;
            acc_q        <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            valid_q      <= 1'b0;
            audio_addr_q <= '0;
            tmpl_addr_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            score_q      <= '0;
        end else begin
            state_q      <= state_d;
            j_q          <= j_d;
            w_q          <= w_d;
            base_q       <= base_d;
            acc_q        <= acc_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            valid_q      <= valid_d;
            audio_addr_q <= audio_addr_d;
            tmpl_addr_q  <= tmpl_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
            score_q      <= score_d;
        end
    end

    assign bus.audio_addr = audio_addr_q;
    assign bus.tmpl_addr  = tmpl_addr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.score      = score_q;

endmodule
